// File: rtl/row_input_ctrl.sv
`default_nettype none
// ============================================================================
// row_input_ctrl : packs 32-bit host words into 8-byte row vectors, queues
//                  them, and feeds them skewed into a systolic array edge.
// Optional ROW_FLUSH_EN adds a flush port that pushes a half-filled vector.
// Revision 1.0
// ============================================================================
module row_input_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_w,
    input  logic        wvalid,
    output logic        wready,
    input  logic        step,
`ifdef ROW_FLUSH_EN
    input  logic        flush,
`endif
    output logic [7:0]  out_r [0:7],
    output logic        out_v [0:7],
    output logic        busy
);

    localparam int        AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic          half;
    logic [31:0]   lo_word;
    logic [63:0]   mem [0:DEPTH-1];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;

    logic          full;
    logic          empty;
    logic          xfer;
    logic          word_push;
    logic          flush_push;
    logic          push;
    logic          pop;
    logic [63:0]   push_data;
    logic [63:0]   head;
    logic [7:0]    lane_busy;

    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);
    // Registered count only: a pop in this cycle does not open wready early.
    assign wready = ~(half & full);
    assign xfer   = wvalid & wready;

    assign word_push = xfer & half;
`ifdef ROW_FLUSH_EN
    assign flush_push = flush & half & ~xfer & ~full;
`else
    assign flush_push = 1'b0;
`endif
    assign push      = word_push | flush_push;
    assign push_data = word_push ? {in_w, lo_word} : {32'h0, lo_word};
    assign pop       = step & ~empty;
    assign head      = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            half    <= 1'b0;
            lo_word <= '0;
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
        end else begin
            if (xfer && !half) begin
                lo_word <= in_w;
                half    <= 1'b1;
            end
            if (push) begin
                half <= 1'b0;
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wptr] <= push_data;
        end
    end

    // Lane k is a (k+1)-deep shift chain; its last stage drives the array edge.
    for (genvar k = 0; k < 8; k++) begin : g_lane
        logic [7:0] d [0:k];
        logic       v [0:k];
        logic       any_v;

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int j = 0; j <= k; j++) begin
                    d[j] <= 8'h00;
                    v[j] <= 1'b0;
                end
            end else if (step) begin
                d[0] <= pop ? head[8*k +: 8] : 8'h00;
                v[0] <= pop;
                for (int j = 1; j <= k; j++) begin
                    d[j] <= d[j-1];
                    v[j] <= v[j-1];
                end
            end
        end

        always_comb begin
            any_v = 1'b0;
            for (int j = 0; j <= k; j++) begin
                any_v = any_v | v[j];
            end
        end

        assign out_r[k]     = d[k];
        assign out_v[k]     = v[k];
        assign lane_busy[k] = any_v;
    end

    assign busy = half | ~empty | (|lane_busy);

endmodule
`default_nettype wire

// File: tb/tb_row_input_ctrl.sv
`default_nettype none
// ============================================================================
// tb_row_input_ctrl : scoreboard bench for row_input_ctrl (DEPTH=4).
// Revision 1.0
// ============================================================================
module tb_row_input_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_w = '0;
    logic        wvalid = 1'b0;
    logic        step = 1'b0;
    logic        wready;
    logic [7:0]  out_r [0:7];
    logic        out_v [0:7];
    logic        busy;
`ifdef ROW_FLUSH_EN
    logic        flush = 1'b0;
`endif

    always #5 clk = ~clk;

    row_input_ctrl #(.DEPTH(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .in_w   (in_w),
        .wvalid (wvalid),
        .wready (wready),
        .step   (step),
`ifdef ROW_FLUSH_EN
        .flush  (flush),
`endif
        .out_r  (out_r),
        .out_v  (out_v),
        .busy   (busy)
    );

    // Scoreboard: expected vectors in push order; each lane walks it independently.
    logic [63:0] vq [$];
    int          lane_idx [0:7];
    logic        last_step = 1'b0;
    int          mon_checks = 0;
    int          mon_fail = 0;
    int          stim_checks = 0;
    int          stim_fail = 0;
    int          total_checks;
    int          total_fail;
    logic [63:0] mon_vec;
    logic [7:0]  mon_exp;

    initial for (int k = 0; k < 8; k++) lane_idx[k] = 0;

    always @(posedge clk) last_step <= step & ~rst;

    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 8; k++) begin
                if (last_step && out_v[k]) begin
                    mon_checks++;
                    if (lane_idx[k] >= vq.size()) begin
                        mon_fail++;
                        $display("FAIL lane%0d_unexpected: got valid byte %02h, expected no output", k, out_r[k]);
                    end else begin
                        mon_vec = vq[lane_idx[k]];
                        mon_exp = mon_vec[8*k +: 8];
                        if (out_r[k] !== mon_exp) begin
                            mon_fail++;
                            $display("FAIL lane%0d_data vec%0d: got %02h expected %02h", k, lane_idx[k], out_r[k], mon_exp);
                        end
                        lane_idx[k]++;
                    end
                end
                if (out_v[k] !== 1'b1) begin
                    mon_checks++;
                    if (out_r[k] !== 8'h00) begin
                        mon_fail++;
                        $display("FAIL lane%0d_zero_when_invalid: got %02h expected 00", k, out_r[k]);
                    end
                end
            end
        end
    end

    function automatic logic [7:0] vmask();
        logic [7:0] m;
        for (int k = 0; k < 8; k++) m[k] = out_v[k];
        return m;
    endfunction

    function automatic logic [63:0] rall();
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = out_r[k];
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        stim_checks++;
        if (act !== exp) begin
            stim_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic        bhalf = 1'b0;
    logic [31:0] bw0 = '0;

    // wvalid rises only at a negedge where wready is already known, so every
    // posedge with wvalid high is an accounted-for transfer.
    task automatic send_word(input logic [31:0] w);
        logic ok;
        ok = 1'b0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            in_w   = w;
            wvalid = 1'b1;
            if (wready) ok = 1'b1;
            @(posedge clk);
            #1;
            wvalid = 1'b0;
        end
        if (!ok) chk("send_timeout", 0, 1);
        else if (!bhalf) begin
            bw0   = w;
            bhalf = 1'b1;
        end else begin
            vq.push_back({w, bw0});
            bhalf = 1'b0;
        end
    endtask

    task automatic wait_idle(input int budget);
        logic done;
        done = 1'b0;
        step = 1'b1;
        for (int t = 0; t < budget && !done; t++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        chk("idle_timeout", done, 1);
    endtask

    // One vector through an idle pipeline under a step schedule; checks the
    // diagonal valid pattern, held lane data and busy each cycle.
    task automatic run_sched(input logic [31:0] w0, input logic [31:0] w1,
                             input logic [15:0] sched, input int ncyc, input string tag);
        logic [63:0] vec;
        int          cnt;
        logic [7:0]  expm;
        vec  = {w1, w0};
        step = 1'b0;
        send_word(w0);
        send_word(w1);
        cnt = 0;
        for (int i = 0; i < ncyc; i++) begin
            step = sched[i];
            @(posedge clk);
            if (sched[i]) cnt++;
            @(negedge clk);
            expm = (cnt >= 1 && cnt <= 8) ? (8'h01 << (cnt - 1)) : 8'h00;
            chk({tag, "_valid"}, vmask(), expm);
            chk({tag, "_busy"}, busy, (cnt <= 8) ? 1 : 0);
            if (cnt >= 1 && cnt <= 8) chk({tag, "_lane_data"}, out_r[cnt-1], vec[8*(cnt-1) +: 8]);
        end
        step = 1'b0;
    endtask

    function automatic logic [31:0] mkword(input int i);
        return {8'(4*i + 3), 8'(4*i + 2), 8'(4*i + 1), 8'(4*i)};
    endfunction

    logic stream_done = 1'b0;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_valid", vmask(), 0);
        chk("reset_data", rall(), 0);
        chk("reset_busy", busy, 0);
        chk("reset_wready", wready, 1);

        // Basic skewed emission, then the same vector with a 3-cycle freeze.
        run_sched(32'h04030201, 32'h08070605, 16'hFFFF, 10, "basic");
        wait_idle(50);
        run_sched(32'hA3A2A1A0, 32'hA7A6A5A4, 16'h3FC7, 14, "freeze");
        wait_idle(50);

        // Fill the FIFO with step low; the tenth word must stall until a pop.
        step = 1'b0;
        for (int i = 0; i < 9; i++) send_word(mkword(i));
        @(negedge clk);
        in_w   = mkword(9);
        wvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("wready_full", wready, 0);
            @(posedge clk);
            if (i < 2) @(negedge clk);
        end
        #1 wvalid = 1'b0;
        step = 1'b1;
        @(posedge clk);
        #1 step = 1'b0;
        @(negedge clk);
        chk("wready_after_pop", wready, 1);
        send_word(mkword(9));
        wait_idle(100);

        // Reset mid-vector, with a word offered on the reset edge.
        step = 1'b0;
        send_word(32'hAABBCCDD);
        rst    = 1'b1;
        in_w   = 32'h11111111;
        wvalid = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        wvalid = 1'b0;
        bhalf  = 1'b0;
        @(negedge clk);
        chk("midreset_busy", busy, 0);
        chk("midreset_wready", wready, 1);
        chk("midreset_valid", vmask(), 0);
        send_word(32'h24232221);
        send_word(32'h28272625);
        wait_idle(50);

`ifdef ROW_FLUSH_EN
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_idle_noop", busy, 0);
        send_word(32'h44332211);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        vq.push_back({32'h0, 32'h44332211});
        bhalf = 1'b0;
        wait_idle(50);
`else
        send_word(32'h44332211);
        step = 1'b1;
        repeat (12) @(negedge clk);
        chk("partial_busy", busy, 1);
        chk("partial_no_output", vmask(), 0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        bhalf = 1'b0;
`endif

        // Streaming with random step and random word gaps.
        fork
            begin
                for (int v = 0; v < 64; v++) begin
                    for (int h = 0; h < 2; h++) begin
                        repeat ($urandom_range(0, 2)) @(posedge clk);
                        send_word($urandom);
                    end
                end
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    @(posedge clk);
                    #1 step = 1'($urandom_range(0, 1));
                end
            end
        join
        wait_idle(200);
        for (int k = 0; k < 8; k++) chk("all_vectors_emitted", lane_idx[k], vq.size());

        total_checks = mon_checks + stim_checks;
        total_fail   = mon_fail + stim_fail;
        $display("End of test - %0d assertions evaluated, %0d failures", total_checks, total_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/row_input_ctrl.md
ROW_INPUT_CTRL -- requirements
Module: row_input_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the row-vector FIFO depth in entries (power of two, >=2).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 in_w  input  32  SHALL carry four packed 8-bit operands from the host.
REQ-005 wvalid  input  1  SHALL qualify in_w.
REQ-006 wready  output  1  SHALL indicate in_w is accepted this cycle.
REQ-007 step  input  1  SHALL advance the array feed by one cycle when high; when low, all outputs and skew stages hold.
REQ-008 out_r  output  8x8 (unpacked [0:7])  SHALL be the per-row operand driven into the systolic array edge.
REQ-009 out_v  output  1x8 (unpacked [0:7])  SHALL be the per-row valid for out_r.
REQ-010 busy  output  1  SHALL be high while any data is held (assembly half, FIFO, or skew stage).

Function
REQ-011 A word transfer SHALL occur on a rising edge with wvalid=1 and wready=1.
REQ-012 The first word of a vector SHALL fill bytes 0-3 (byte0=in_w[7:0] ... byte3=in_w[31:24]) and set half=1.
REQ-013 The second word SHALL fill bytes 4-7 in the same order, push the 8-byte vector into the FIFO, and clear half.
REQ-014 wready SHALL be 0 only when half=1 and the FIFO is full (registered count, no same-cycle pop bypass).
REQ-015 On a cycle with step=1 and FIFO non-empty, the head vector SHALL be popped and injected into the skew pipeline with valid=1; if empty, a bubble (valid=0, data 0) SHALL be injected.
REQ-016 Lane k (0..7) SHALL present injected byte k on out_r[k]/out_v[k] after exactly k+1 step cycles (lane 0 one cycle, lane 7 eight).
REQ-017 Simultaneous push and pop SHALL both take effect; count unchanged.
REQ-018 FIFO read/write pointers SHALL wrap modulo DEPTH without loss or duplication.
REQ-019 Words presented while wready=0 SHALL be neither consumed nor corrupt the held half vector.
REQ-020 When out_v[k]=0, out_r[k] SHALL be 0.
REQ-021 busy SHALL equal half OR (count!=0) OR any skew-stage valid.

Reset
REQ-022 rst=1 SHALL clear half, FIFO count and pointers, and all skew stages on the next edge, discarding in-flight data, even mid-vector.
REQ-023 After reset: out_r all 0, out_v all 0, busy=0, wready=1.
REQ-024 A transfer on the same edge as rst=1 SHALL be discarded.

Configuration
REQ-025 Macro ROW_FLUSH_EN, when defined, SHALL add input port flush (1 bit); flush=1 with half=1, no word transfer, and FIFO not full SHALL push the partial vector with bytes 4-7 = 0 and clear half.
REQ-026 flush with half=0 or FIFO full SHALL have no effect; flush coinciding with a second-word transfer SHALL be ignored (the normal push wins).
REQ-027 Without ROW_FLUSH_EN, port flush SHALL not exist and a partial vector SHALL wait indefinitely for its second word.

Verification
REQ-028 Reset, then words 0x04030201, 0x08070605, step=1 constantly -> out_r[k]=k+1 with out_v[k]=1 exactly one cycle each, lane k appearing k+1 cycles after pop, busy falls after lane 7.
REQ-029 step=0, push 5 vectors (DEPTH=4) -> wready=0 on the 10th word (half=1, full); one step pulse -> wready=1 next cycle, 10th word accepted, no data lost.
REQ-030 step held low mid-stream for 3 cycles -> out_r/out_v frozen, skew alignment preserved after resume.
REQ-031 Push first word 0xAABBCCDD then assert rst -> next cycle busy=0, wready=1; following two words form a clean new vector.
REQ-032 ROW_FLUSH_EN: word 0x44332211 then flush -> vector 11,22,33,44,0,0,0,0 emitted; without macro, same word leaves busy=1 and no output.
REQ-033 Continuous streaming of 64 vectors with random step/wvalid -> output order matches input order, pointers wrap cleanly.
